// File: rtl/mmio_packet_port_if.sv
// Bus and router signal bundle for mmio_packet_port.
// Latency: none (wires only).
// Backpressure: carries tx_valid/tx_ready and rx_valid/rx_ready handshakes.
interface mmio_packet_port_if #(
    parameter int PKT_BITS = 54
);
    logic                bus_write;
    logic                bus_read;
    logic [31:0]         bus_addr;
    logic [31:0]         bus_wdata;
    logic [31:0]         bus_rdata;
    logic                bus_hit;
    logic [PKT_BITS-1:0] tx_packet;
    logic                tx_valid;
    logic                tx_ready;
    logic [PKT_BITS-1:0] rx_packet;
    logic                rx_valid;
    logic                rx_ready;

    // Packet port side: consumes bus strobes and rx offers, produces read data and tx packets.
    modport slave (
        input  bus_write, bus_read, bus_addr, bus_wdata, tx_ready, rx_packet, rx_valid,
        output bus_rdata, bus_hit, tx_packet, tx_valid, rx_ready
    );

    // CPU wrapper / router side.
    modport master (
        output bus_write, bus_read, bus_addr, bus_wdata, tx_ready, rx_packet, rx_valid,
        input  bus_rdata, bus_hit, tx_packet, tx_valid, rx_ready
    );
endinterface

// File: rtl/mmio_packet_port.sv
// Memory-mapped packet port: staged TX fields + TX FIFO, RX FIFO with field readout. Optional PKT_COUNTERS_EN.
// Latency: read data/hit 1 cycle after bus_read; tx_valid 1 cycle after COMMIT.
// Backpressure: TX holds head until tx_ready (COMMIT when full drops + sticky overflow); rx_ready = !rx_full.
module mmio_packet_port #(
    parameter logic [31:0] BASE_ADDR    = 32'h2000_0000,
    parameter int          COORD_BITS   = 1,
    parameter int          MCAST_BITS   = 1,
    parameter int          TYPE_BITS    = 1,
    parameter int          MCOORD_BITS  = 8,
    parameter int          ELEMENT_BITS = 32,
    parameter int          TX_DEPTH     = 4,
    parameter int          RX_DEPTH     = 4
) (
    input logic              clk,
    input logic              reset,
    mmio_packet_port_if.slave bus
);
    localparam int PKT_BITS = 2*COORD_BITS + MCAST_BITS + 2 + TYPE_BITS + 2*MCOORD_BITS + ELEMENT_BITS;
    localparam int TXA = $clog2(TX_DEPTH);
    localparam int RXA = $clog2(RX_DEPTH);
    localparam logic [TXA:0] TX_FULL_CNT = (TXA+1)'(TX_DEPTH);
    localparam logic [RXA:0] RX_FULL_CNT = (RXA+1)'(RX_DEPTH);

    // Field LSB positions inside a packet, element at the bottom.
    localparam int MY_LSB = ELEMENT_BITS;
    localparam int MX_LSB = MY_LSB + MCOORD_BITS;
    localparam int TY_LSB = MX_LSB + MCOORD_BITS;
    localparam int RS_LSB = TY_LSB + TYPE_BITS;
    localparam int DN_LSB = RS_LSB + 1;
    localparam int MC_LSB = DN_LSB + 1;
    localparam int Y_LSB  = MC_LSB + MCAST_BITS;
    localparam int X_LSB  = Y_LSB + COORD_BITS;

    // Bus decode
    logic       hit;
    logic [3:0] off;
    logic       wr_en, rd_en;
    assign hit   = (bus.bus_addr[31:6] == BASE_ADDR[31:6]);
    assign off   = bus.bus_addr[5:2];
    assign wr_en = bus.bus_write && hit;
    assign rd_en = bus.bus_read && hit;

    // Staging registers
    logic [COORD_BITS-1:0]   dx_q, dy_q;
    logic [MCAST_BITS-1:0]   mc_q;
    logic [TYPE_BITS+1:0]    flags_q;
    logic [MCOORD_BITS-1:0]  mx_q, my_q;
    logic [ELEMENT_BITS-1:0] el_q;
    logic [PKT_BITS-1:0]     staged;
    assign staged = {dx_q, dy_q, mc_q, flags_q[0], flags_q[1], flags_q[TYPE_BITS+1:2], mx_q, my_q, el_q};

    // TX FIFO state
    logic [PKT_BITS-1:0] tx_mem [TX_DEPTH];
    logic [TXA-1:0]      tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [TXA:0]        tx_cnt_q, tx_cnt_d;
    logic                tx_ovf_q, tx_ovf_d;
    logic                tx_full, tx_pop, tx_push, commit;

    // RX FIFO state
    logic [PKT_BITS-1:0] rx_mem [RX_DEPTH];
    logic [RXA-1:0]      rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [RXA:0]        rx_cnt_q, rx_cnt_d;
    logic                rx_full, rx_avail, rx_push, rx_pop;
    logic [PKT_BITS-1:0] rx_head;

    logic [31:0] rd_dat;
    logic [31:0] bus_rdata_q;
    logic        bus_hit_q;

    assign tx_full         = (tx_cnt_q == TX_FULL_CNT);
    assign bus.tx_valid    = (tx_cnt_q != '0);
    assign bus.tx_packet   = tx_mem[tx_rptr_q];
    assign tx_pop          = bus.tx_valid && bus.tx_ready;
    assign commit          = wr_en && (off == 4'd7);
    // A full FIFO still accepts a COMMIT when the head leaves in the same cycle.
    assign tx_push         = commit && (!tx_full || tx_pop);

    assign rx_full         = (rx_cnt_q == RX_FULL_CNT);
    assign rx_avail        = (rx_cnt_q != '0);
    assign bus.rx_ready    = !rx_full;
    assign rx_push         = bus.rx_valid && bus.rx_ready;
    assign rx_pop          = wr_en && (off == 4'd13) && rx_avail;
    assign rx_head         = rx_mem[rx_rptr_q];

    assign bus.bus_rdata   = bus_rdata_q;
    assign bus.bus_hit     = bus_hit_q;

    // Staging field writes, truncated to each field's width
    always_ff @(posedge clk) begin
        if (reset) begin
            dx_q <= '0; dy_q <= '0; mc_q <= '0; flags_q <= '0;
            mx_q <= '0; my_q <= '0; el_q <= '0;
        end else if (wr_en) begin
            case (off)
                4'd0: dx_q    <= bus.bus_wdata[COORD_BITS-1:0];
                4'd1: dy_q    <= bus.bus_wdata[COORD_BITS-1:0];
                4'd2: mc_q    <= bus.bus_wdata[MCAST_BITS-1:0];
                4'd3: flags_q <= bus.bus_wdata[TYPE_BITS+1:0];
                4'd4: mx_q    <= bus.bus_wdata[MCOORD_BITS-1:0];
                4'd5: my_q    <= bus.bus_wdata[MCOORD_BITS-1:0];
                4'd6: el_q    <= bus.bus_wdata[ELEMENT_BITS-1:0];
                default: ;
            endcase
        end
    end

    // TX FIFO pointer, count and overflow next state
    always_comb begin
        tx_wptr_d = tx_wptr_q;
        tx_rptr_d = tx_rptr_q;
        tx_cnt_d  = tx_cnt_q;
        tx_ovf_d  = tx_ovf_q;
        if (tx_push) tx_wptr_d = tx_wptr_q + TXA'(1);
        if (tx_pop)  tx_rptr_d = tx_rptr_q + TXA'(1);
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + (TXA+1)'(1);
            2'b01:   tx_cnt_d = tx_cnt_q - (TXA+1)'(1);
            default: tx_cnt_d = tx_cnt_q;
        endcase
        if (wr_en && (off == 4'd8) && bus.bus_wdata[4]) tx_ovf_d = 1'b0;
        if (commit && !tx_push) tx_ovf_d = 1'b1;
    end

    // RX FIFO pointer and count next state
    always_comb begin
        rx_wptr_d = rx_wptr_q;
        rx_rptr_d = rx_rptr_q;
        rx_cnt_d  = rx_cnt_q;
        if (rx_push) rx_wptr_d = rx_wptr_q + RXA'(1);
        if (rx_pop)  rx_rptr_d = rx_rptr_q + RXA'(1);
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + (RXA+1)'(1);
            2'b01:   rx_cnt_d = rx_cnt_q - (RXA+1)'(1);
            default: rx_cnt_d = rx_cnt_q;
        endcase
    end

    // FIFO control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wptr_q <= '0; tx_rptr_q <= '0; tx_cnt_q <= '0; tx_ovf_q <= 1'b0;
            rx_wptr_q <= '0; rx_rptr_q <= '0; rx_cnt_q <= '0;
        end else begin
            tx_wptr_q <= tx_wptr_d; tx_rptr_q <= tx_rptr_d; tx_cnt_q <= tx_cnt_d; tx_ovf_q <= tx_ovf_d;
            rx_wptr_q <= rx_wptr_d; rx_rptr_q <= rx_rptr_d; rx_cnt_q <= rx_cnt_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr_q] <= staged;
        if (rx_push) rx_mem[rx_wptr_q] <= bus.rx_packet;
    end

`ifdef PKT_COUNTERS_EN
    logic [31:0] tx_sent_q, rx_recv_q;

    // Free-running packet counters, cleared together by a write to offset 14
    always_ff @(posedge clk) begin
        if (reset || (wr_en && (off == 4'd14))) begin
            tx_sent_q <= '0;
            rx_recv_q <= '0;
        end else begin
            if (tx_pop)  tx_sent_q <= tx_sent_q + 32'd1;
            if (rx_push) rx_recv_q <= rx_recv_q + 32'd1;
        end
    end
`endif

    // Read data mux; RX fields read as zero while the RX FIFO is empty
    always_comb begin
        rd_dat = '0;
        case (off)
            4'd0:  rd_dat = 32'(dx_q);
            4'd1:  rd_dat = 32'(dy_q);
            4'd2:  rd_dat = 32'(mc_q);
            4'd3:  rd_dat = 32'(flags_q);
            4'd4:  rd_dat = 32'(mx_q);
            4'd5:  rd_dat = 32'(my_q);
            4'd6:  rd_dat = 32'(el_q);
            4'd8:  rd_dat = {8'd0, 8'(rx_cnt_q), 8'(tx_cnt_q), 3'b000, tx_ovf_q, 2'b00, rx_avail, tx_full};
            4'd9:  rd_dat = rx_avail ? 32'({rx_head[Y_LSB +: COORD_BITS], rx_head[X_LSB +: COORD_BITS]}) : '0;
            4'd10: rd_dat = rx_avail ? 32'({rx_head[MC_LSB +: MCAST_BITS], rx_head[TY_LSB +: TYPE_BITS],
                                             rx_head[RS_LSB], rx_head[DN_LSB]}) : '0;
            4'd11: rd_dat = rx_avail ? 32'(rx_head[MX_LSB +: MCOORD_BITS]) : '0;
            4'd12: rd_dat = rx_avail ? 32'(rx_head[MY_LSB +: MCOORD_BITS]) : '0;
            4'd13: rd_dat = rx_avail ? 32'(rx_head[0 +: ELEMENT_BITS]) : '0;
`ifdef PKT_COUNTERS_EN
            4'd14: rd_dat = tx_sent_q;
            4'd15: rd_dat = rx_recv_q;
`endif
            default: rd_dat = '0;
        endcase
    end

    // Registered read response, one cycle behind the bus read strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_rdata_q <= '0;
            bus_hit_q   <= 1'b0;
        end else begin
            bus_hit_q   <= rd_en;
            bus_rdata_q <= rd_en ? rd_dat : '0;
        end
    end

    // Bits of the bus that carry no information for this block
    logic unused_bits;
    assign unused_bits = &{1'b0, bus.bus_wdata, bus.bus_addr[1:0]};
endmodule

// File: tb/tb_mmio_packet_port.sv
module tb_mmio_packet_port;
    localparam logic [31:0] BASE = 32'h2000_0000;
    localparam int PB = 54;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mmio_packet_port_if #(.PKT_BITS(PB)) bif ();
    mmio_packet_port dut (.clk(clk), .reset(reset), .bus(bif));

    int total = 0;
    int bad = 0;
    logic [PB-1:0] txq [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [PB-1:0] pk(input logic x, input logic y, input logic mc, input logic dn,
                                          input logic rs, input logic ty, input logic [7:0] mx,
                                          input logic [7:0] my, input logic [31:0] el);
        return {x, y, mc, dn, rs, ty, mx, my, el};
    endfunction

    task automatic wr(input int off, input logic [31:0] d);
        bif.bus_write = 1'b1;
        bif.bus_addr  = BASE + 32'(off * 4);
        bif.bus_wdata = d;
        @(posedge clk); #1;
        bif.bus_write = 1'b0;
    endtask

    task automatic rd(input int off, input logic [31:0] exp, input string tag);
        bif.bus_read = 1'b1;
        bif.bus_addr = BASE + 32'(off * 4);
        @(posedge clk); #1;
        bif.bus_read = 1'b0;
        chk({tag, ".hit"}, 64'(bif.bus_hit), 64'd1);
        chk(tag, 64'(bif.bus_rdata), 64'(exp));
    endtask

    task automatic tx_take(input string tag);
        int n = 0;
        while (!bif.tx_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".valid"}, 64'(bif.tx_valid), 64'd1);
        chk({tag, ".sbq"}, 64'(txq.size() > 0), 64'd1);
        if (txq.size() > 0) chk(tag, 64'(bif.tx_packet), 64'(txq.pop_front()));
        bif.tx_ready = 1'b1;
        @(posedge clk); #1;
        bif.tx_ready = 1'b0;
    endtask

    task automatic rx_put(input logic [31:0] el, input string tag);
        bif.rx_packet = pk(1, 1, 1, 1, 0, 1, 8'd7, 8'd9, el);
        bif.rx_valid  = 1'b1;
        chk({tag, ".rdy"}, 64'(bif.rx_ready), 64'd1);
        @(posedge clk); #1;
        bif.rx_valid = 1'b0;
    endtask

    initial begin
        bif.bus_write = 0; bif.bus_read = 0; bif.bus_addr = 0; bif.bus_wdata = 0;
        bif.tx_ready = 0; bif.rx_packet = '0; bif.rx_valid = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        chk("rst.tx_valid", 64'(bif.tx_valid), 0);
        chk("rst.rx_ready", 64'(bif.rx_ready), 1);
        chk("rst.hit", 64'(bif.bus_hit), 0);
        chk("rst.rdata", 64'(bif.bus_rdata), 0);
        rd(8, 32'h0, "rst.status");

        // Staging, truncation, readback, out-of-window access
        wr(0, 32'hFFFF_FFFF); rd(0, 32'h1, "trunc.x");
        wr(0, 1); wr(1, 0); wr(4, 3); wr(5, 5); wr(6, 32'hDEAD_BEEF);
        rd(6, 32'hDEAD_BEEF, "stage.elem");
        rd(4, 32'h3, "stage.mx");
        rd(3, 32'h0, "stage.flags");
        bif.bus_write = 1'b1; bif.bus_addr = BASE + 32'd64 + 32'd28;
        @(posedge clk); #1; bif.bus_write = 1'b0;
        chk("oow.commit", 64'(bif.tx_valid), 0);
        bif.bus_read = 1'b1; bif.bus_addr = BASE + 32'd64 + 32'd32;
        @(posedge clk); #1; bif.bus_read = 1'b0;
        chk("oow.hit", 64'(bif.bus_hit), 0);

        // Single packet send
        txq.push_back(pk(1, 0, 0, 0, 0, 0, 8'd3, 8'd5, 32'hDEAD_BEEF));
        wr(7, 0);
        chk("tx1.valid_next", 64'(bif.tx_valid), 1);
        rd(8, 32'h100, "tx1.status");
        tx_take("tx1.pkt");
        rd(8, 32'h0, "tx1.drained");
        rd(13, 32'h0, "rx.empty_elem");

        // Overflow: five commits into a four-deep FIFO
        for (int i = 0; i < 5; i++) begin
            wr(6, 32'(100 + i));
            if (i < 4) txq.push_back(pk(1, 0, 0, 0, 0, 0, 8'd3, 8'd5, 32'(100 + i)));
            wr(7, 0);
        end
        rd(8, 32'h411, "ovf.status");
        wr(8, 32'h10);
        rd(8, 32'h401, "ovf.cleared");

        // COMMIT in the same cycle as a handshake while full
        wr(6, 32'h55);
        txq.push_back(pk(1, 0, 0, 0, 0, 0, 8'd3, 8'd5, 32'h55));
        chk("same.head", 64'(bif.tx_packet), 64'(txq.pop_front()));
        bif.tx_ready = 1'b1; bif.bus_write = 1'b1; bif.bus_addr = BASE + 32'd28;
        @(posedge clk); #1;
        bif.tx_ready = 1'b0; bif.bus_write = 1'b0;
        rd(8, 32'h401, "same.status");
        for (int i = 0; i < 4; i++) tx_take("same.order");
        rd(8, 32'h0, "same.drained");
        chk("same.sb_empty", 64'(txq.size()), 0);

        // RX push, field reads, pops
        rx_put(1, "rx.p1"); rx_put(2, "rx.p2"); rx_put(3, "rx.p3");
        rd(8, 32'h0003_0002, "rx.status3");
        rd(13, 32'h1, "rx.elem1");
        rd(9, 32'h3, "rx.src");
        rd(10, 32'hD, "rx.flags");
        rd(11, 32'h7, "rx.mx");
        rd(12, 32'h9, "rx.my");
        wr(13, 0);
        rd(13, 32'h2, "rx.elem2");
        wr(13, 0); wr(13, 0);
        rd(8, 32'h0, "rx.status0");
        rd(13, 32'h0, "rx.elem_empty");
        rd(9, 32'h0, "rx.src_empty");
        wr(13, 0);
        rd(8, 32'h0, "rx.pop_empty");

        // RX full with a held offer and a pop
        for (int i = 11; i < 15; i++) rx_put(32'(i), "rxf.fill");
        rd(8, 32'h0004_0002, "rxf.status");
        chk("rxf.not_ready", 64'(bif.rx_ready), 0);
        bif.rx_packet = pk(1, 1, 1, 1, 0, 1, 8'd7, 8'd9, 32'd15);
        bif.rx_valid = 1'b1;
        wr(13, 0);
        chk("rxf.ready_after_pop", 64'(bif.rx_ready), 1);
        @(posedge clk); #1;
        bif.rx_valid = 1'b0;
        rd(8, 32'h0004_0002, "rxf.cnt4");
        for (int i = 12; i < 16; i++) begin
            rd(13, 32'(i), "rxf.order");
            wr(13, 0);
        end
        rd(8, 32'h0, "rxf.drained");

        // Partial fill, counters, then reset mid-operation
        wr(7, 0); wr(7, 0);
        rx_put(21, "rst2.rx"); rx_put(22, "rst2.rx"); rx_put(23, "rst2.rx");
        rd(8, 32'h0003_0202, "pre_rst.status");
`ifdef PKT_COUNTERS_EN
        rd(14, 32'd6, "cnt.tx_sent");
        rd(15, 32'd11, "cnt.rx_recv");
`else
        rd(14, 32'd0, "cnt.off14");
        rd(15, 32'd0, "cnt.off15");
`endif
        bif.tx_ready = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bif.tx_ready = 1'b0;
        txq.delete();
        chk("rst2.tx_valid", 64'(bif.tx_valid), 0);
        chk("rst2.rx_ready", 64'(bif.rx_ready), 1);
        rd(8, 32'h0, "rst2.status");
`ifdef PKT_COUNTERS_EN
        rd(14, 32'd0, "rst2.tx_sent");
        rd(15, 32'd0, "rst2.rx_recv");
        rx_put(5, "cnt.rx");
        rd(15, 32'd1, "cnt.rx_one");
        wr(14, 0);
        rd(15, 32'd0, "cnt.cleared");
`else
        wr(14, 32'hFFFF_FFFF);
        rd(14, 32'd0, "cnt.off14_wr");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
